// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and defaults for the instruction memory loader
package imem_loader_pkg;

  localparam int DEPTH_DEFAULT  = 1024;
  localparam int LEN_W_DEFAULT  = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// rtl/imem_loader_word_packer.sv - packs little-endian bytes into 32-bit words with a one-cycle strobe
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_en,
  output logic        word_last,
  output logic [31:0] word_out,
  output logic        word_strobe
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_PER_WORD - 1);

  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]      asm_q, asm_d;
  logic [31:0]      word_q, word_d;
  logic             strobe_q, strobe_d;

  // word_last lets the owner of the address counter act in the same cycle the final byte lands
  assign word_last   = (byte_cnt_q == LAST_CNT);
  assign word_out    = word_q;
  assign word_strobe = strobe_q;

  // Assemble bytes separately from the output word so the published word stays put while the next one fills
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    word_d     = word_q;
    strobe_d   = 1'b0;
    if (clear) begin
      byte_cnt_d = '0;
      asm_d      = '0;
    end else if (byte_en) begin
      asm_d[8*byte_cnt_q +: 8] = byte_in;
      if (byte_cnt_q == LAST_CNT) begin
        word_d     = asm_d;
        strobe_d   = 1'b1;
        byte_cnt_d = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end
  end

  // Packer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      asm_q      <= '0;
      word_q     <= '0;
      strobe_q   <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      word_q     <= word_d;
      strobe_q   <= strobe_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader into instruction memory, gates cpu_run on checksum
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             cpu_run,
  output logic [LEN_W-1:0] words_loaded
);

  state_t           state_q, state_d;
  logic [7:0]       csum_q, csum_d;
  logic [LEN_W-1:0] length_q, length_d;
  logic [LEN_W-1:0] word_idx_q, word_idx_d;
  logic [31:0]      addr_q, addr_d;
  logic             clear;
  logic             accept;
  logic             data_en;
  logic             word_last;
  logic [LEN_W-1:0] new_len;

  assign busy     = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                    (state_q == ST_DATA) || (state_q == ST_CHECK);
  assign done     = (state_q == ST_DONE);
  assign error    = (state_q == ST_ERR);
  assign cpu_run  = (state_q == ST_DONE);
  assign rx_ready = busy;
  assign accept   = rx_valid && busy;
  assign data_en  = accept && (state_q == ST_DATA);
  assign new_len  = LEN_W'({rx_data, length_q[7:0]});

  assign mem_addr     = addr_q;
  assign words_loaded = word_idx_q;

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .byte_in    (rx_data),
    .byte_en    (data_en),
    .word_last  (word_last),
    .word_out   (mem_wdata),
    .word_strobe(mem_we)
  );

  // Next state, checksum, length header and word address bookkeeping
  always_comb begin
    state_d    = state_q;
    csum_d     = csum_q;
    length_d   = length_q;
    word_idx_d = word_idx_q;
    addr_d     = addr_q;
    clear      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_LEN0;
          csum_d     = '0;
          length_d   = '0;
          word_idx_d = '0;
          clear      = 1'b1;
        end
      end
      ST_LEN0: begin
        if (accept) begin
          length_d[7:0] = rx_data;
          csum_d        = csum_q ^ rx_data;
          state_d       = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (accept) begin
          length_d = new_len;
          csum_d   = csum_q ^ rx_data;
          if (32'(new_len) > 32'(DEPTH)) begin
            state_d = ST_ERR;
          end else if (new_len == '0) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          csum_d = csum_q ^ rx_data;
          if (word_last) begin
            // Address is latched with the pre-increment index so it lines up with the strobe
            addr_d     = {{(32-LEN_W-2){1'b0}}, word_idx_q, 2'b00};
            word_idx_d = word_idx_q + 1'b1;
            if (word_idx_d == length_q) begin
              state_d = ST_CHECK;
            end
          end
        end
      end
      ST_CHECK: begin
        if (accept) begin
          state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Loader state registers; reset abandons any load in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      csum_q     <= '0;
      length_q   <= '0;
      word_idx_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      csum_q     <= csum_d;
      length_q   <= length_d;
      word_idx_q <= word_idx_d;
      addr_q     <= addr_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a stream-level model
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_run;
  logic [15:0] words_loaded;

  imem_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .cpu_run     (cpu_run),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wdata);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_run"}, cpu_run, 1'b0);
    check({tag, "_rdy"}, rx_ready, 1'b0);
    check({tag, "_we"}, mem_we, 1'b0);
    check({tag, "_wl"}, words_loaded, 16'd0);
    check({tag, "_addr"}, mem_addr, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  function automatic bq_t make_prog(input int len, input bit good);
    bq_t q;
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    b = len[7:0];  q.push_back(b); cs ^= b;
    b = len[15:8]; q.push_back(b); cs ^= b;
    for (int i = 0; i < 4 * len; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      cs ^= b;
    end
    if (!good) cs ^= 8'($urandom_range(1, 255));
    q.push_back(cs);
    return q;
  endfunction

  // Drives one load; limit >= 0 truncates the stream after that many bytes
  task automatic run_load(input string tag, input bq_t b, input int gap, input int limit, input bit poke);
    int  len, consumed, n_send, n_exp, w, last_idx;
    bit  too_long, exp_ok, stalled;
    logic [7:0]  cs;
    logic [31:0] exp_word;
    int  acc[$];

    // reference: what the stream should do, from the protocol rules alone
    len      = int'(b[0]) | (int'(b[1]) << 8);
    too_long = (len > 1024);
    consumed = too_long ? 2 : (2 + 4 * len + 1);
    n_send   = (limit >= 0 && limit < consumed) ? limit : consumed;
    cs = 8'h00;
    for (int i = 0; i < consumed - 1; i++) cs ^= b[i];
    exp_ok = !too_long && (b[consumed-1] == cs);
    n_exp = 0;
    if (!too_long) begin
      for (int k = 0; k < len; k++) if (2 + 4 * k + 3 < n_send) n_exp++;
    end

    got_addr.delete(); got_data.delete(); got_cyc.delete();

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, "_start_busy"}, busy, 1'b1);
    check({tag, "_start_run"}, cpu_run, 1'b0);
    check({tag, "_start_wl"}, words_loaded, 16'd0);

    stalled = 1'b0;
    for (int i = 0; i < n_send && !stalled; i++) begin
      if (i > 0) @(negedge clk);
      repeat ($urandom_range(0, gap)) begin
        rx_valid = 1'b0;
        if (poke && $urandom_range(0, 3) == 0) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      rx_valid = 1'b1;
      rx_data  = b[i];
      w = 0;
      while (!rx_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!rx_ready) begin
        check({tag, "_ready_timeout"}, 1'b0, 1'b1);
        stalled = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        acc.push_back(cyc);
      end
    end
    rx_valid = 1'b0;

    if (!stalled && n_send == consumed) begin
      check({tag, "_done"}, done, exp_ok);
      check({tag, "_error"}, error, !exp_ok);
      check({tag, "_run"}, cpu_run, exp_ok);
      check({tag, "_busy_end"}, busy, 1'b0);
      check({tag, "_rdy_end"}, rx_ready, 1'b0);
      check({tag, "_wl"}, words_loaded, too_long ? 16'd0 : 16'(len));
    end else if (!stalled) begin
      check({tag, "_busy_mid"}, busy, 1'b1);
    end

    repeat (2) @(negedge clk);
    check({tag, "_nwrites"}, got_addr.size(), n_exp);
    for (int k = 0; k < n_exp && k < got_addr.size(); k++) begin
      last_idx = 2 + 4 * k + 3;
      exp_word = {b[last_idx], b[last_idx-1], b[last_idx-2], b[last_idx-3]};
      check($sformatf("%s_addr%0d", tag, k), got_addr[k], 32'(4 * k));
      check($sformatf("%s_data%0d", tag, k), got_data[k], exp_word);
      if (last_idx < acc.size())
        check($sformatf("%s_lat%0d", tag, k), got_cyc[k], acc[last_idx]);
    end
  endtask

  bq_t good_stream;
  bq_t bad_stream;
  bq_t p;

  initial begin
    rst = 1'b1; start = 1'b1; rx_valid = 1'b1; rx_data = 8'hFF;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst_hold");
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0;
    @(negedge clk);

    good_stream = '{8'h02, 8'h00, 8'h93, 8'h82, 8'h22, 8'h00, 8'h33, 8'hE2, 8'h62, 8'h00, 8'h82};
    run_load("good_b2b", good_stream, 0, -1, 1'b0);
    if (got_data.size() == 2) begin
      check("good_w0_const", got_data[0], 32'h00228293);
      check("good_w1_const", got_data[1], 32'h0062E233);
    end else begin
      check("good_write_count", got_data.size(), 2);
    end

    bad_stream = good_stream;
    bad_stream[10] = 8'h83;
    run_load("bad_csum", bad_stream, 3, -1, 1'b1);

    p = '{8'h01, 8'h04};
    run_load("too_long", p, 1, -1, 1'b0);

    p = '{8'h00, 8'h00, 8'h00};
    run_load("zero_len", p, 0, -1, 1'b0);
    run_load("after_zero", good_stream, 2, -1, 1'b0);

    run_load("mid_rst", good_stream, 1, 8, 1'b0);
    @(negedge clk) rst = 1'b1;
    #1;
    check_idle_outputs("mid_rst_out");
    @(negedge clk) rst = 1'b0;
    run_load("post_rst", good_stream, 0, -1, 1'b0);

    for (int n = 0; n < 20; n++) begin
      p = make_prog($urandom_range(0, 6), ($urandom_range(0, 3) != 0));
      run_load($sformatf("rnd%0d", n), p, $urandom_range(0, 2), -1, 1'b1);
    end

    p = make_prog(1024, 1'b1);
    run_load("depth_max", p, 0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
